// File: rtl/camera_capture.sv
// Camera byte-stream capture: pairs bytes into RGB565 pixels, tags them with (x, y)
// and reports per-frame completion and geometry check against H_ACTIVE x V_ACTIVE.
module camera_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        pixelClk,
    input  logic        reset,
    input  logic        captureEn,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  camData,
    output logic [9:0]  outX,
    output logic [8:0]  outY,
    output logic [15:0] pixelOut,
    output logic        writeEn,
    output logic        frameDone,
    output logic        frameOk,
    output logic [7:0]  frameCount
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

    state_t        state_q, state_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic          phase_q, phase_d;
    logic [7:0]    hi_q, hi_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          line_over_q, line_over_d;
    logic          frame_bad_q, frame_bad_d;
    logic          frame_over_q, frame_over_d;
    logic [9:0]    out_x_q, out_x_d;
    logic [8:0]    out_y_q, out_y_d;
    logic [15:0]   pixel_q, pixel_d;
    logic          write_en_q, write_en_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_ok_q, frame_ok_d;
    logic [7:0]    frame_count_q, frame_count_d;

    logic vs_fall, vs_rise, href_fall;

    assign vs_fall   = vsync_q & ~vsync;
    assign vs_rise   = ~vsync_q & vsync;
    assign href_fall = href_q & ~href;

    // x saturates at H_ACTIVE, so line_over remembers pixels beyond it; likewise
    // frame_over remembers lines beyond V_ACTIVE once y has saturated.
    always_comb begin
        state_d       = state_q;
        vsync_d       = vsync;
        href_d        = href;
        phase_d       = phase_q;
        hi_d          = hi_q;
        x_d           = x_q;
        y_d           = y_q;
        line_over_d   = line_over_q;
        frame_bad_d   = frame_bad_q;
        frame_over_d  = frame_over_q;
        out_x_d       = out_x_q;
        out_y_d       = out_y_q;
        pixel_d       = pixel_q;
        write_en_d    = 1'b0;
        frame_done_d  = 1'b0;
        frame_ok_d    = frame_ok_q;
        frame_count_d = frame_count_q;

        case (state_q)
            IDLE: begin
                if (captureEn) begin
                    state_d = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (!captureEn) begin
                    state_d = IDLE;
                end else if (vs_fall) begin
                    state_d      = ACTIVE;
                    x_d          = '0;
                    y_d          = '0;
                    phase_d      = 1'b0;
                    line_over_d  = 1'b0;
                    frame_bad_d  = 1'b0;
                    frame_over_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (href && !vsync) begin
                    if (!phase_q) begin
                        hi_d    = camData;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (x_q != X_MAX) begin
                            x_d = x_q + 1'b1;
                            if (y_q != Y_MAX) begin
                                write_en_d = 1'b1;
                                out_x_d    = 10'(x_q);
                                out_y_d    = 9'(y_q);
                                pixel_d    = {hi_q, camData};
                            end
                        end else begin
                            line_over_d = 1'b1;
                        end
                    end
                end

                // End of line: a dangling high byte is dropped by clearing the phase.
                if (href_fall) begin
                    x_d         = '0;
                    phase_d     = 1'b0;
                    line_over_d = 1'b0;
                    if (x_q != '0) begin
                        if (y_q != Y_MAX) begin
                            y_d = y_q + 1'b1;
                        end else begin
                            frame_over_d = 1'b1;
                        end
                        if (x_q != X_MAX || line_over_q) begin
                            frame_bad_d = 1'b1;
                        end
                    end
                end

                if (vs_rise) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                    frame_ok_d    = !frame_bad_d && !frame_over_d && (y_d == Y_MAX);
                    state_d       = captureEn ? WAIT_VS : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pixelClk) begin
        if (reset) begin
            state_q       <= IDLE;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            line_over_q   <= 1'b0;
            frame_bad_q   <= 1'b0;
            frame_over_q  <= 1'b0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            pixel_q       <= '0;
            write_en_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_over_q   <= line_over_d;
            frame_bad_q   <= frame_bad_d;
            frame_over_q  <= frame_over_d;
            out_x_q       <= out_x_d;
            out_y_q       <= out_y_d;
            pixel_q       <= pixel_d;
            write_en_q    <= write_en_d;
            frame_done_q  <= frame_done_d;
            frame_ok_q    <= frame_ok_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign outX       = out_x_q;
    assign outY       = out_y_q;
    assign pixelOut   = pixel_q;
    assign writeEn    = write_en_q;
    assign frameDone  = frame_done_q;
    assign frameOk    = frame_ok_q;
    assign frameCount = frame_count_q;

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture using a reduced 8x4 frame so whole frames stay short.
module tb_camera_capture;

    localparam int H = 8;
    localparam int V = 4;
    localparam int LINE_BYTES = 2 * H;

    logic        pixelClk = 1'b0;
    logic        reset = 1'b1;
    logic        captureEn = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  camData = 8'h00;
    logic [9:0]  outX;
    logic [8:0]  outY;
    logic [15:0] pixelOut;
    logic        writeEn;
    logic        frameDone;
    logic        frameOk;
    logic [7:0]  frameCount;

    int error_count = 0;
    int check_count = 0;

    int          wr_count = 0;
    int          done_count = 0;
    logic        last_ok = 1'b0;
    logic [9:0]  last_x = '0;
    logic [8:0]  last_y = '0;
    logic [15:0] last_pix = '0;
    logic [9:0]  max_x = '0;
    logic        got_first = 1'b0;
    logic [9:0]  first_x = '0;
    logic [8:0]  first_y = '0;
    logic [15:0] first_pix = '0;

    camera_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .pixelClk  (pixelClk),
        .reset     (reset),
        .captureEn (captureEn),
        .vsync     (vsync),
        .href      (href),
        .camData   (camData),
        .outX      (outX),
        .outY      (outY),
        .pixelOut  (pixelOut),
        .writeEn   (writeEn),
        .frameDone (frameDone),
        .frameOk   (frameOk),
        .frameCount(frameCount)
    );

    always #5 pixelClk = ~pixelClk;

    // Records strobes and frame completions just after each rising edge.
    always @(posedge pixelClk) begin
        #1;
        if (writeEn) begin
            wr_count++;
            last_x   = outX;
            last_y   = outY;
            last_pix = pixelOut;
            if (outX > max_x) max_x = outX;
            if (!got_first) begin
                got_first = 1'b1;
                first_x   = outX;
                first_y   = outY;
                first_pix = pixelOut;
            end
        end
        if (frameDone) begin
            done_count++;
            last_ok = frameOk;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge pixelClk);
    endtask

    function automatic logic [7:0] pat(input int line, input int idx);
        logic [3:0] l;
        logic [3:0] i;
        l = 4'(line);
        i = 4'(idx);
        return {l, i};
    endfunction

    task automatic clearStats();
        wr_count   = 0;
        done_count = 0;
        max_x      = '0;
        got_first  = 1'b0;
    endtask

    task automatic sendBytes(input int line, input int from, input int upto, input int armAt);
        for (int i = from; i < upto; i++) begin
            if (i == armAt) captureEn = 1'b1;
            href    = 1'b1;
            camData = pat(line, i);
            tick();
        end
        href    = 1'b0;
        camData = 8'h00;
        tick();
        tick();
    endtask

    task automatic sendLine(input int line, input int nbytes);
        sendBytes(line, 0, nbytes, -1);
    endtask

    task automatic sendFrame();
        for (int l = 0; l < V; l++) sendLine(l, LINE_BYTES);
    endtask

    task automatic endFrame();
        vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic startFrame();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic checkFrame(input string tag, input int strobes, input logic ok, input logic [7:0] count);
        checkOutput({tag, "_strobes"}, wr_count, strobes);
        checkOutput({tag, "_done"}, done_count, 1);
        checkOutput({tag, "_ok"}, last_ok, ok);
        checkOutput({tag, "_count"}, frameCount, count);
    endtask

    task automatic applyStimulus();
        // Reset state
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checkOutput("rst_we", writeEn, 0);
        checkOutput("rst_x", outX, 0);
        checkOutput("rst_y", outY, 0);
        checkOutput("rst_pix", pixelOut, 0);
        checkOutput("rst_done", frameDone, 0);
        checkOutput("rst_ok", frameOk, 0);
        checkOutput("rst_count", frameCount, 0);

        // Full frame with byte-order probe on line 0
        captureEn = 1'b1;
        tick();
        endFrame();
        startFrame();
        clearStats();
        href = 1'b1;
        camData = 8'hF8;
        tick();
        camData = 8'h1F;
        tick();
        checkOutput("order_we", writeEn, 1);
        checkOutput("order_pix", pixelOut, 16'hF81F);
        checkOutput("order_x", outX, 0);
        checkOutput("order_y", outY, 0);
        sendBytes(0, 2, LINE_BYTES, -1);
        for (int l = 1; l < V; l++) sendLine(l, LINE_BYTES);
        endFrame();
        checkFrame("full", H * V, 1'b1, 8'd1);
        checkOutput("full_last_x", last_x, H - 1);
        checkOutput("full_last_y", last_y, V - 1);
        checkOutput("full_last_pix", last_pix, 16'h3E3F);
        startFrame();

        // Long first line: extra pixels dropped, frame flagged bad
        clearStats();
        sendLine(0, LINE_BYTES + 4);
        for (int l = 1; l < V; l++) sendLine(l, LINE_BYTES);
        endFrame();
        checkFrame("long", H * V, 1'b0, 8'd2);
        checkOutput("long_max_x", max_x, H - 1);
        startFrame();

        // Odd first line: trailing byte discarded, next line starts clean
        clearStats();
        sendLine(0, LINE_BYTES + 1);
        checkOutput("odd_strobes", wr_count, H);
        got_first = 1'b0;
        sendLine(1, LINE_BYTES);
        checkOutput("odd_next_x", first_x, 0);
        checkOutput("odd_next_y", first_y, 1);
        checkOutput("odd_next_pix", first_pix, 16'h1011);
        sendLine(2, LINE_BYTES);
        sendLine(3, LINE_BYTES);
        endFrame();
        checkFrame("odd", H * V, 1'b1, 8'd3);
        startFrame();

        // captureEn dropped mid-frame: frame finishes, then capture stops
        clearStats();
        sendLine(0, LINE_BYTES);
        captureEn = 1'b0;
        for (int l = 1; l < V; l++) sendLine(l, LINE_BYTES);
        endFrame();
        checkFrame("dis", H * V, 1'b1, 8'd4);
        startFrame();
        clearStats();
        sendFrame();
        endFrame();
        checkOutput("idle_strobes", wr_count, 0);
        checkOutput("idle_done", done_count, 0);
        checkOutput("idle_count", frameCount, 4);
        startFrame();

        // Arming during line 1: nothing until the next vsync fall
        clearStats();
        sendLine(0, LINE_BYTES);
        sendBytes(1, 0, LINE_BYTES, 5);
        sendLine(2, LINE_BYTES);
        sendLine(3, LINE_BYTES);
        endFrame();
        checkOutput("arm_strobes", wr_count, 0);
        checkOutput("arm_done", done_count, 0);
        startFrame();
        clearStats();
        sendFrame();
        endFrame();
        checkFrame("arm", H * V, 1'b1, 8'd5);
        checkOutput("arm_first_x", first_x, 0);
        checkOutput("arm_first_y", first_y, 0);
        checkOutput("arm_first_pix", first_pix, 16'h0001);
        startFrame();

        // Reset mid-frame: outputs cleared, capture waits for a fresh frame
        sendLine(0, LINE_BYTES);
        sendLine(1, LINE_BYTES);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mrst_we", writeEn, 0);
        checkOutput("mrst_x", outX, 0);
        checkOutput("mrst_y", outY, 0);
        checkOutput("mrst_pix", pixelOut, 0);
        checkOutput("mrst_ok", frameOk, 0);
        checkOutput("mrst_count", frameCount, 0);
        clearStats();
        sendLine(2, LINE_BYTES);
        sendLine(3, LINE_BYTES);
        endFrame();
        checkOutput("mrst_strobes", wr_count, 0);
        checkOutput("mrst_done", done_count, 0);
        startFrame();
        clearStats();
        sendFrame();
        endFrame();
        checkFrame("post", H * V, 1'b1, 8'd1);
        checkOutput("post_last_x", last_x, H - 1);
        checkOutput("post_last_y", last_y, V - 1);
        startFrame();
    endtask

    initial begin
        applyStimulus();
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
